// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch bus: request/address out, ready/data back.
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/pc_fetch_unit.sv
// PC holder and fetch/execute sequencer for the single-cycle core.
// Fetches from imem with a ready handshake, presents instr for one EXEC cycle, then loads next_pc.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pc_fetch_unit_if.master         imem,
  input  logic [31:0]             next_pc,
  input  logic                    stall,
  input  logic                    halt,
  output logic [31:0]             pc,
  output logic [31:0]             pc_plus4,
  output logic [31:0]             instr,
  output logic                    instr_valid,
  output logic [31:0]             retired,
  output logic                    halted,
  output logic                    fault,
  output logic [1:0]              fault_cause
);

  localparam int unsigned WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_MISALGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALTED,
    S_FAULT
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [31:0]         pc_d, instr_d, retired_d;
  logic [1:0]          cause_d;
  logic                req_d, valid_d, halted_d, fault_d;
  logic                misaligned_c;
  logic                timeout_hit_c;

  assign misaligned_c   = |next_pc[1:0];
  // Hit on the edge whose increment would bring the wait count up to TIMEOUT.
  assign timeout_hit_c  = (TIMEOUT != 0) && ((32'(wait_q) + 32'd1) >= 32'(TIMEOUT));
  assign pc_plus4       = pc + 32'd4;
  assign imem.imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        if (imem.imem_ready)   state_d = S_EXEC;
        else if (timeout_hit_c) state_d = S_FAULT;
      end
      S_EXEC: begin
        if (halt)              state_d = S_HALTED;
        else if (stall)        state_d = S_EXEC;
        else if (misaligned_c) state_d = S_FAULT;
        else                   state_d = S_FETCH;
      end
      S_HALTED: state_d = S_HALTED;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Next values for every registered output, decided from the current state and inputs.
  always_comb begin
    req_d     = (state_d == S_FETCH);
    valid_d   = (state_d == S_EXEC);
    halted_d  = (state_d == S_HALTED);
    fault_d   = (state_d == S_FAULT);
    pc_d      = pc;
    instr_d   = instr;
    retired_d = retired;
    cause_d   = fault_cause;
    wait_d    = wait_q;
    case (state_q)
      S_FETCH: begin
        if (imem.imem_ready) begin
          instr_d = imem.imem_rdata;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
          if (timeout_hit_c) cause_d = CAUSE_TIMEOUT;
        end
      end
      S_EXEC: begin
        if (!halt && !stall) begin
          if (misaligned_c) begin
            cause_d = CAUSE_MISALGN;
          end else begin
            pc_d      = next_pc;
            retired_d = retired + 32'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= RESET_PC;
      instr         <= '0;
      retired       <= '0;
      fault_cause   <= CAUSE_NONE;
      wait_q        <= '0;
      imem.imem_req <= 1'b0;
      instr_valid   <= 1'b0;
      halted        <= 1'b0;
      fault         <= 1'b0;
    end else begin
      pc            <= pc_d;
      instr         <= instr_d;
      retired       <= retired_d;
      fault_cause   <= cause_d;
      wait_q        <= wait_d;
      imem.imem_req <= req_d;
      instr_valid   <= valid_d;
      halted        <= halted_d;
      fault         <= fault_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: fetched words go to a scoreboard and are checked in EXEC.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] next_pc;
  logic        stall;
  logic        halt;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] retired;
  logic        halted;
  logic        fault;
  logic [1:0]  fault_cause;

  logic        rdy;
  logic        use_ovr;
  logic [31:0] ovr_word;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } sb_t;

  sb_t         sb_q[$];
  int          n_tests;
  int          n_fail;
  logic [31:0] exp_pc;
  logic [31:0] exp_ret;
  logic [31:0] exp_instr;

  pc_fetch_unit_if bus ();

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  assign bus.imem_ready = rdy;
  assign bus.imem_rdata = use_ovr ? ovr_word : mem_word(bus.imem_addr);

  pc_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .TIMEOUT  (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (bus),
    .next_pc     (next_pc),
    .stall       (stall),
    .halt        (halt),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr       (instr),
    .instr_valid (instr_valid),
    .retired     (retired),
    .halted      (halted),
    .fault       (fault),
    .fault_cause (fault_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_pc", pc, 32'h0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_retired", retired, 32'h0);
    chk("rst_cause", 32'(fault_cause), 32'h0);
    chk("rst_req", 32'(bus.imem_req), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
  endtask

  // Called at posedge+1; pulses reset inside the cycle, then steps through IDLE into FETCH.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 check_reset_vals();
    #2 rst_n = 1'b1;
    halt    = 1'b0;
    stall   = 1'b0;
    rdy     = 1'b1;
    use_ovr = 1'b0;
    sb_q.delete();
    exp_pc  = 32'h0;
    exp_ret = 32'h0;
    tick();
  endtask

  task automatic fetch(input int waits, input logic ovr, input logic [31:0] word);
    for (int i = 0; i < waits; i++) begin
      rdy = 1'b0;
      chk("wait_req", 32'(bus.imem_req), 32'h1);
      chk("wait_addr", bus.imem_addr, exp_pc);
      tick();
    end
    rdy      = 1'b1;
    use_ovr  = ovr;
    ovr_word = word;
    chk("fetch_req", 32'(bus.imem_req), 32'h1);
    chk("fetch_addr", bus.imem_addr, exp_pc);
    chk("fetch_plus4", pc_plus4, exp_pc + 32'd4);
    chk("fetch_valid", 32'(instr_valid), 32'h0);
    sb_q.push_back('{pc: exp_pc, word: (ovr ? word : mem_word(exp_pc))});
    tick();
  endtask

  task automatic exec_check();
    sb_t e;
    int  n;
    n = 0;
    while (instr_valid !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk("exec_valid", 32'(instr_valid), 32'h1);
    chk("exec_req", 32'(bus.imem_req), 32'h0);
    if (sb_q.size() == 0) begin
      chk("exec_sb_empty", 32'(sb_q.size()), 32'h1);
    end else begin
      e = sb_q.pop_front();
      exp_instr = e.word;
      chk("exec_instr", instr, e.word);
      chk("exec_pc", pc, e.pc);
    end
  endtask

  task automatic retire(input logic [31:0] npc);
    next_pc = npc;
    tick();
    exp_pc = npc;
    exp_ret++;
    chk("ret_count", retired, exp_ret);
    chk("ret_pc", pc, exp_pc);
    chk("ret_valid", 32'(instr_valid), 32'h0);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    next_pc  = 32'h0;
    stall    = 1'b0;
    halt     = 1'b0;
    rdy      = 1'b1;
    use_ovr  = 1'b0;
    ovr_word = 32'h0;
    exp_pc   = 32'h0;
    exp_ret  = 32'h0;
    exp_instr = 32'h0;

    repeat (2) @(posedge clk);
    #1 check_reset_vals();
    #4 rst_n = 1'b1;
    tick();

    // Zero-wait sequential fetch 0, 4, 8
    fetch(0, 1'b0, 32'h0);
    exec_check();
    retire(32'h4);
    fetch(0, 1'b0, 32'h0);
    exec_check();
    retire(32'h8);
    fetch(0, 1'b0, 32'h0);
    exec_check();
    retire(32'hC);
    chk("zw_retired3", retired, 32'd3);

    // Three wait states, then jump to the top word to exercise pc_plus4 wrap
    fetch(3, 1'b1, 32'hDEAD_BEEF);
    exec_check();
    chk("ws_instr", instr, 32'hDEAD_BEEF);
    retire(32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4, 32'h0);
    fetch(0, 1'b0, 32'h0);
    exec_check();

    // Jump to 0x40
    retire(32'h40);
    fetch(0, 1'b0, 32'h0);
    exec_check();

    // Two-cycle stall holds instr/pc/retired
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall_valid", 32'(instr_valid), 32'h1);
      chk("stall_pc", pc, exp_pc);
      chk("stall_instr", instr, exp_instr);
      chk("stall_retired", retired, exp_ret);
    end
    stall = 1'b0;
    retire(32'h44);

    // Reset asserted asynchronously in the middle of a waiting fetch
    rdy = 1'b0;
    tick();
    tick();
    chk("midf_req", 32'(bus.imem_req), 32'h1);
    chk("midf_addr", bus.imem_addr, 32'h44);
    do_reset();
    fetch(0, 1'b0, 32'h0);
    exec_check();

    // halt wins over stall
    halt  = 1'b1;
    stall = 1'b1;
    tick();
    chk("halt_halted", 32'(halted), 32'h1);
    chk("halt_pc", pc, 32'h0);
    chk("halt_req", 32'(bus.imem_req), 32'h0);
    chk("halt_valid", 32'(instr_valid), 32'h0);
    chk("halt_retired", retired, 32'h0);
    tick();
    chk("halt_hold", 32'(halted), 32'h1);
    chk("halt_hold_req", 32'(bus.imem_req), 32'h0);
    do_reset();

    // Misaligned next_pc
    fetch(0, 1'b0, 32'h0);
    exec_check();
    next_pc = 32'h42;
    tick();
    chk("mis_fault", 32'(fault), 32'h1);
    chk("mis_cause", 32'(fault_cause), 32'h1);
    chk("mis_pc", pc, 32'h0);
    chk("mis_retired", retired, 32'h0);
    tick();
    chk("mis_hold_cause", 32'(fault_cause), 32'h1);
    chk("mis_hold_req", 32'(bus.imem_req), 32'h0);
    do_reset();

    // Fetch timeout with TIMEOUT=4
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_nofault", 32'(fault), 32'h0);
      chk("to_req", 32'(bus.imem_req), 32'h1);
    end
    tick();
    chk("to_fault", 32'(fault), 32'h1);
    chk("to_cause", 32'(fault_cause), 32'h2);
    chk("to_instr", instr, 32'h0);
    chk("to_req_off", 32'(bus.imem_req), 32'h0);
    rdy = 1'b1;
    tick();
    chk("to_hold", 32'(fault), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and instruction-fetch sequencer for the single-cycle core. It holds the architectural PC and fetches each instruction from instruction memory with a ready handshake. It presents the instruction to the datapath for one execute cycle. At the end of that cycle it loads the next PC chosen by the jump/branch select mux. It also provides PC+4 to that mux, so it sits both upstream and downstream of the next-PC selection logic.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset; must be word aligned.
- TIMEOUT, 255, maximum FETCH cycles waiting for imem_ready before a fault; 0 disables the timeout.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- next_pc  in  32  next PC from the jump/branch select mux; sampled in EXEC.
- stall  in  1  hold the current instruction in EXEC.
- halt  in  1  stop the core after the current EXEC.
- imem_ready  in  1  memory has valid imem_rdata this cycle.
- imem_rdata  in  32  instruction word from memory.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; always equal to pc.
- pc  out  32  current PC.
- pc_plus4  out  32  pc + 4, combinational, wraps modulo 2^32.
- instr  out  32  registered instruction word.
- instr_valid  out  1  instr is valid for the datapath (EXEC state).
- retired  out  32  count of instructions that completed with a PC update; wraps.
- halted  out  1  core is in the HALTED state.
- fault  out  1  core is in the FAULT state.
- fault_cause  out  2  00 none, 01 misaligned next_pc, 10 fetch timeout.

## Operation
- States: IDLE, FETCH, EXEC, HALTED, FAULT. Encoding is free.
- IDLE: entered on reset. Moves to FETCH on the first clock edge after rst_n deasserts.
- FETCH:
  - imem_req=1 and imem_addr=pc.
  - When imem_ready=1: instr<=imem_rdata, wait counter clears, next state EXEC.
  - When imem_ready=0: the wait counter increments.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT: go to FAULT with cause 10. instr is unchanged.
  - imem_ready is ignored in every other state.
- EXEC: instr_valid=1 and imem_req=0. Priority on each edge is halt > stall > misaligned > update:
  - halt=1: go to HALTED. pc and retired are unchanged.
  - stall=1: stay in EXEC. pc, instr and retired are held.
  - next_pc[1:0]!=0: go to FAULT with cause 01. pc is unchanged.
  - Otherwise: pc<=next_pc, retired<=retired+1, next state FETCH.
- HALTED: halted=1. All outputs hold. Only reset leaves this state.
- FAULT: fault=1 and fault_cause holds its value. All outputs hold. Only reset leaves this state.
- The wait counter is wide enough to hold TIMEOUT.
- Reset (asynchronous, takes effect immediately, including mid-fetch or mid-stall):
  - pc=RESET_PC, instr=0, retired=0, fault_cause=00.
  - imem_req=0, instr_valid=0, halted=0, fault=0.
  - State returns to IDLE.

## Timing
- Zero-wait memory: each instruction takes 2 cycles (FETCH, EXEC). instr_valid is high every other cycle.
- N wait cycles (imem_ready low for N FETCH cycles) stretch FETCH to N+1 cycles.
- instr_valid rises in the cycle after the cycle in which imem_ready=1 is sampled.
- next_pc is sampled only on the edge that ends an EXEC cycle. The new pc is visible in the next FETCH cycle.
- A stall of K cycles keeps instr_valid high for K+1 consecutive cycles, with identical instr and pc throughout.
- pc_plus4 and imem_addr follow pc combinationally. pc=32'hFFFF_FFFC gives pc_plus4=0.
- Status outputs are registered and assert on the edge that enters their state:
  - halted and fault rise one edge after the deciding EXEC cycle.
  - For a timeout, fault rises on the edge where the counter reaches TIMEOUT.

## Test plan
- **Zero-wait fetch.** Reset with RESET_PC=0, imem_ready=1, next_pc driven from pc_plus4 -> imem_addr sequence 0, 4, 8 at 2-cycle spacing; retired=3 after 6 cycles past IDLE.
- **Wait states.** imem_ready low for 3 cycles, then high with rdata=32'hDEAD_BEEF -> imem_req high for 4 cycles with imem_addr stable; next cycle instr=32'hDEAD_BEEF and instr_valid=1.
- **Jump.** next_pc=32'h40 during EXEC -> next FETCH has imem_addr=32'h40 and retired increments by 1.
- **Stall.** stall=1 for 2 EXEC cycles -> instr_valid high for 3 cycles, pc unchanged, retired incremented once.
- **Halt and misaligned.**
  - halt=1 together with stall=1 -> halted=1 next cycle, pc unchanged, imem_req stays 0.
  - next_pc=32'h42 -> fault=1 with fault_cause=01.
- **Timeout and reset.**
  - TIMEOUT=4 with imem_ready held low -> fault=1 with fault_cause=10 at the 4th FETCH edge.
  - rst_n pulsed low mid-FETCH -> all outputs return to reset values asynchronously, and the next fetch address is RESET_PC.
